// File: rtl/ixc_skid_pkg.sv
// Shared types and defaults for the ixc skid buffer slice.
package ixc_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int SKID_W = 10;

endpackage

// File: rtl/ixc_skid_entry.sv
// W-bit storage register with load enable and synchronous active-low clear.
module ixc_skid_entry #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ixc_skid_10.sv
// Two-entry skid buffer: HEAD drives L, SKID absorbs one beat of back-pressure.
// IN_RDY and OUT_VLD come straight from flops so neither handshake input reaches an output.
module ixc_skid_10
    import ixc_skid_pkg::*;
#(
    parameter int W = SKID_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         FLUSH,
    input  logic [W-1:0] R,
    input  logic         IN_VLD,
    output logic         IN_RDY,
    output logic [W-1:0] L,
    output logic         OUT_VLD,
    input  logic         OUT_RDY
);

    skid_state_e  state_q, state_d;
    logic         in_rdy_q, out_vld_q;
    logic         push, pop;
    logic         head_en, skid_en;
    logic [W-1:0] head_d, head_q, skid_q;

    assign push    = IN_VLD & in_rdy_q;
    assign pop     = out_vld_q & OUT_RDY;
    assign IN_RDY  = in_rdy_q;
    assign OUT_VLD = out_vld_q;
    assign L       = head_q;

    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = R;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_en = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    head_en = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_en = 1'b1;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only drops occupancy; stored data stays put so L holds its last value.
        if (FLUSH) begin
            state_d = EMPTY;
            head_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= EMPTY;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= (state_d != FULL);
            out_vld_q <= (state_d != EMPTY);
        end
    end

    ixc_skid_entry #(.W(W)) u_head (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (head_en),
        .d     (head_d),
        .q     (head_q)
    );

    ixc_skid_entry #(.W(W)) u_skid (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (skid_en),
        .d     (R),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_ixc_skid_10.sv
// Directed self-checking bench for ixc_skid_10 with hand-computed expectations.
module tb_ixc_skid_10;

    logic       CLK = 1'b0;
    logic       RST_N, FLUSH, IN_VLD, OUT_RDY;
    logic [9:0] R;
    logic       IN_RDY, OUT_VLD;
    logic [9:0] L;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ixc_skid_10 #(.W(10)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .FLUSH   (FLUSH),
        .R       (R),
        .IN_VLD  (IN_VLD),
        .IN_RDY  (IN_RDY),
        .L       (L),
        .OUT_VLD (OUT_VLD),
        .OUT_RDY (OUT_RDY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1ns later, away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic vld, input logic [9:0] data);
        chk({tag, ".in_rdy"},  32'(IN_RDY),  32'(rdy));
        chk({tag, ".out_vld"}, 32'(OUT_VLD), 32'(vld));
        chk({tag, ".l"},       32'(L),       32'(data));
    endtask

    initial begin
        RST_N = 1'b0; FLUSH = 1'b0; OUT_RDY = 1'b0;
        IN_VLD = 1'b1; R = 10'h3AB;

        // Reset held 3 cycles with IN_VLD high: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 1'b0, 1'b0, 10'h000);
        end
        RST_N = 1'b1;
        step();
        chk_out("first_edge", 1'b1, 1'b0, 10'h000);
        IN_VLD = 1'b0;
        step();
        chk_out("idle", 1'b1, 1'b0, 10'h000);

        // Streaming 0x001..0x3FF: L follows R one cycle later with no bubbles.
        OUT_RDY = 1'b1; IN_VLD = 1'b1;
        for (int v = 1; v <= 1023; v++) begin
            R = 10'(v);
            step();
            chk_out("stream", 1'b1, 1'b1, 10'(v));
        end
        IN_VLD = 1'b0;
        step();
        chk_out("stream_drain", 1'b1, 1'b0, 10'h3FF);

        // Back-pressure fills both entries; a third push is ignored.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; R = 10'h155;
        step();
        chk_out("bp_one", 1'b1, 1'b1, 10'h155);
        R = 10'h2AA;
        step();
        chk_out("bp_full", 1'b0, 1'b1, 10'h155);
        R = 10'h0F0;
        step();
        chk_out("bp_ignored", 1'b0, 1'b1, 10'h155);
        IN_VLD = 1'b0; OUT_RDY = 1'b1;
        step();
        chk_out("bp_pop1", 1'b1, 1'b1, 10'h2AA);
        step();
        chk_out("bp_pop2", 1'b1, 1'b0, 10'h2AA);
        step();
        chk_out("bp_empty_hold", 1'b1, 1'b0, 10'h2AA);

        // Simultaneous push and pop in ONE keeps occupancy at one.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; R = 10'h011;
        step();
        chk_out("pp_load", 1'b1, 1'b1, 10'h011);
        OUT_RDY = 1'b1; R = 10'h022;
        step();
        chk_out("pp_swap", 1'b1, 1'b1, 10'h022);
        IN_VLD = 1'b0; OUT_RDY = 1'b0;
        step();
        chk_out("pp_still_one", 1'b1, 1'b1, 10'h022);
        OUT_RDY = 1'b1;
        step();
        chk_out("pp_drain", 1'b1, 1'b0, 10'h022);

        // Flush from FULL overrides a same-cycle push and pop.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; R = 10'h0A1;
        step();
        R = 10'h0B2;
        step();
        chk_out("fl_full", 1'b0, 1'b1, 10'h0A1);
        FLUSH = 1'b1; OUT_RDY = 1'b1; R = 10'h0C3;
        step();
        chk_out("fl_flush", 1'b1, 1'b0, 10'h0A1);
        FLUSH = 1'b0; IN_VLD = 1'b0;
        step();
        chk_out("fl_idle", 1'b1, 1'b0, 10'h0A1);
        OUT_RDY = 1'b0; IN_VLD = 1'b1; R = 10'h0D4;
        step();
        chk_out("fl_repush", 1'b1, 1'b1, 10'h0D4);
        IN_VLD = 1'b0; OUT_RDY = 1'b1;
        step();
        chk_out("fl_repop", 1'b1, 1'b0, 10'h0D4);

        // Reset in FULL discards everything and blocks the concurrent push.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; R = 10'h101;
        step();
        R = 10'h202;
        step();
        chk_out("mr_full", 1'b0, 1'b1, 10'h101);
        RST_N = 1'b0; OUT_RDY = 1'b1; FLUSH = 1'b1;
        step();
        chk_out("mr_reset", 1'b0, 1'b0, 10'h000);
        RST_N = 1'b1; FLUSH = 1'b0; IN_VLD = 1'b0;
        step();
        chk_out("mr_release", 1'b1, 1'b0, 10'h000);
        IN_VLD = 1'b1; R = 10'h3FF;
        step();
        chk_out("mr_push", 1'b1, 1'b1, 10'h3FF);
        IN_VLD = 1'b0;
        step();
        chk_out("mr_drain", 1'b1, 1'b0, 10'h3FF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ixc_skid_10.md
IXC_SKID_10 -- requirements
Module: ixc_skid_10

Interface
REQ-001 Parameter: W, 10, data width of R and L.
REQ-002 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 FLUSH  input  1  synchronous discard of all buffered entries.
REQ-005 R  input  W  upstream data.
REQ-006 IN_VLD  input  1  upstream data valid.
REQ-007 IN_RDY  output  1  block accepts data this cycle; registered.
REQ-008 L  output  W  downstream data, head entry; drives the 10-bit assign bus.
REQ-009 OUT_VLD  output  1  L holds a valid entry; registered.
REQ-010 OUT_RDY  input  1  downstream accepts L this cycle.

Function
REQ-011 The block SHALL be a 2-entry skid buffer: HEAD (drives L) and SKID (overflow); push = IN_VLD & IN_RDY; pop = OUT_VLD & OUT_RDY.
REQ-012 The state SHALL be one of EMPTY, ONE, FULL; OUT_VLD = (state != EMPTY); IN_RDY = (state != FULL) after the first post-reset cycle.
REQ-013 EMPTY: push -> ONE, HEAD <= R; no push -> EMPTY.
REQ-014 ONE: push & !pop -> FULL, SKID <= R; pop & !push -> EMPTY; push & pop -> ONE, HEAD <= R; neither -> ONE.
REQ-015 FULL: pop -> ONE, HEAD <= SKID; no pop -> FULL; IN_VLD ignored (IN_RDY = 0).
REQ-016 Latency R -> L SHALL be exactly 1 cycle when entering EMPTY or ONE with simultaneous pop.
REQ-017 Sustained IN_VLD = OUT_RDY = 1 SHALL yield one transfer per cycle with no bubbles.
REQ-018 Data SHALL leave in arrival order; no entry dropped or duplicated.
REQ-019 IN_VLD while IN_RDY = 0 SHALL have no effect on state or data.
REQ-020 L SHALL hold its value while OUT_VLD = 1 and OUT_RDY = 0.
REQ-021 L SHALL hold its last value (not forced to 0) when state returns to EMPTY.
REQ-022 FLUSH = 1 SHALL set state EMPTY next cycle, overriding push and pop in the same cycle; HEAD/SKID contents unchanged; IN_RDY = 1 next cycle.
REQ-023 IN_RDY and OUT_VLD SHALL be flop outputs; no combinational path from OUT_RDY or IN_VLD to any output.
REQ-024 HEAD and SKID SHALL be exactly W bits wide; no width extension or truncation.

Reset
REQ-025 RST_N = 0 at a rising CLK edge SHALL set state EMPTY, OUT_VLD = 0, IN_RDY = 0, L = 0, SKID = 0.
REQ-026 First edge with RST_N = 1 SHALL set IN_RDY = 1; no push is accepted before that edge.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; reset overrides FLUSH, push and pop.

Structure
REQ-028 Package ixc_skid_pkg SHALL hold the state enum (EMPTY, ONE, FULL, 2-bit encoding) and the default width constant 10.
REQ-029 One sub-module, ixc_skid_entry, SHALL implement a W-bit enabled register with synchronous active-low clear; it is instantiated twice, for HEAD and SKID.
REQ-030 The block SHALL contain no latches, no asynchronous logic and no clock gating.

Verification
REQ-031 Reset: RST_N low for 3 cycles, then high -> OUT_VLD = 0, L = 0 throughout; IN_RDY = 0 until the first high edge, then 1.
REQ-032 Streaming: push 0x001..0x3FF consecutively with OUT_RDY = 1 -> L shows the same sequence 1 cycle later; one transfer per cycle.
REQ-033 Back-pressure: OUT_RDY = 0, push 0x155 then 0x2AA -> state FULL, IN_RDY = 0, L = 0x155; a third push of 0x0F0 is ignored; OUT_RDY = 1 -> L = 0x155, then 0x2AA, then EMPTY.
REQ-034 Simultaneous push/pop in ONE: HEAD = 0x011, push 0x022 with OUT_RDY = 1 -> next cycle L = 0x022, state ONE.
REQ-035 Flush: in FULL, assert FLUSH together with OUT_RDY = 1 and IN_VLD = 1 -> next cycle OUT_VLD = 0, IN_RDY = 1, no transfer counted.
REQ-036 Mid-operation reset: in FULL, RST_N low for 1 cycle -> OUT_VLD = 0, L = 0; after release, push 0x3FF -> L = 0x3FF 1 cycle later.
